// File: rtl/i2c_target.sv
// i2c_target: 7-bit address I2C target with synchronised, glitch-filtered SCL/SDA sampling.
// Optional macro I2C_TARGET_CLOCK_STRETCH_EN: hold SCL low until the user supplies read data.
module i2c_target #(
   parameter logic [6:0] ADDRESS      = 7'h50,
   parameter int         FILTER_DEPTH = 3
) (
   input  logic       clk_in,
   input  logic       rst_n,
   inout  wire        scl,
   inout  wire        sda,
   input  logic       rx_ack,
   input  logic [7:0] data_tx,
   input  logic       tx_valid,
   output logic       busy,
   output logic       addressed,
   output logic       mode,
   output logic [7:0] data_rx,
   output logic       rx_valid,
   output logic       tx_request,
   output logic       nack,
   output logic [2:0] o_dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_ADDR      = 3'd1,
      S_ADDR_ACK  = 3'd2,
      S_WRITE     = 3'd3,
      S_WRITE_ACK = 3'd4,
      S_READ      = 3'd5,
      S_READ_ACK  = 3'd6,
      S_WAIT_STOP = 3'd7
   } state_t;

   localparam logic [3:0] CNT_MAX = 4'(FILTER_DEPTH - 1);

   // Index 0 carries SCL, index 1 carries SDA through the input path.
   logic [1:0] r_sync1, r_sync2, r_filt, r_rise, r_fall;
   logic [3:0] r_cnt [2];

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 2'b11;
         r_sync2 <= 2'b11;
         r_filt  <= 2'b11;
         r_rise  <= 2'b00;
         r_fall  <= 2'b00;
         for (int i = 0; i < 2; i++) r_cnt[i] <= '0;
      end else begin
         r_sync1 <= {sda, scl};
         r_sync2 <= r_sync1;
         for (int i = 0; i < 2; i++) begin
            r_rise[i] <= 1'b0;
            r_fall[i] <= 1'b0;
            if (r_sync2[i] == r_filt[i]) begin
               r_cnt[i] <= '0;
            end else if (r_cnt[i] == CNT_MAX) begin
               r_cnt[i]  <= '0;
               r_filt[i] <= r_sync2[i];
               r_rise[i] <= r_sync2[i];
               r_fall[i] <= ~r_sync2[i];
            end else begin
               r_cnt[i] <= r_cnt[i] + 4'd1;
            end
         end
      end
   end

   logic w_scl_f, w_sda_f, w_scl_rise, w_scl_fall, w_start, w_stop;
   assign w_scl_f    = r_filt[0];
   assign w_sda_f    = r_filt[1];
   assign w_scl_rise = r_rise[0];
   assign w_scl_fall = r_fall[0];
   assign w_start    = r_fall[1] & w_scl_f;
   assign w_stop     = r_rise[1] & w_scl_f;

   state_t     r_state, w_state_nxt;
   logic [3:0] r_bitcnt, w_bitcnt_nxt;
   logic [6:0] r_shift, w_shift_nxt;
   logic       r_phase, w_phase_nxt;
   logic       r_sda_oe, w_sda_oe_nxt;
   logic       r_addressed, w_addressed_nxt;
   logic       r_busy, w_busy_nxt;
   logic       r_mode, w_mode_nxt;
   logic       r_nack, w_nack_nxt;
   logic [7:0] r_data_rx, w_data_rx_nxt;
   logic       r_rx_valid, w_rx_valid_nxt;
   logic       r_tx_req, w_tx_req_nxt;
   logic       r_ack_en, w_ack_en_nxt;
   logic       w_load;
`ifdef I2C_TARGET_CLOCK_STRETCH_EN
   logic       r_stretch, w_stretch_nxt, r_stretch_d;
`endif

   // r_phase marks the second half of an ACK slot (after its opening SCL fall)
   // or, in READ_ACK, that the controller ACKed and a reload is due.
   always_comb begin
      w_state_nxt     = r_state;
      w_bitcnt_nxt    = r_bitcnt;
      w_shift_nxt     = r_shift;
      w_phase_nxt     = r_phase;
      w_sda_oe_nxt    = r_sda_oe;
      w_addressed_nxt = r_addressed;
      w_busy_nxt      = r_busy;
      w_mode_nxt      = r_mode;
      w_nack_nxt      = r_nack;
      w_data_rx_nxt   = r_data_rx;
      w_rx_valid_nxt  = 1'b0;
      w_tx_req_nxt    = 1'b0;
      w_ack_en_nxt    = r_ack_en;
      w_load          = 1'b0;
`ifdef I2C_TARGET_CLOCK_STRETCH_EN
      w_stretch_nxt   = r_stretch;
`endif
      if (w_stop) begin
         w_state_nxt     = S_IDLE;
         w_busy_nxt      = 1'b0;
         w_addressed_nxt = 1'b0;
         w_sda_oe_nxt    = 1'b0;
         w_phase_nxt     = 1'b0;
         w_bitcnt_nxt    = '0;
`ifdef I2C_TARGET_CLOCK_STRETCH_EN
         w_stretch_nxt   = 1'b0;
`endif
      end else if (w_start) begin
         w_state_nxt     = S_ADDR;
         w_busy_nxt      = 1'b1;
         w_addressed_nxt = 1'b0;
         w_nack_nxt      = 1'b0;
         w_sda_oe_nxt    = 1'b0;
         w_phase_nxt     = 1'b0;
         w_bitcnt_nxt    = '0;
`ifdef I2C_TARGET_CLOCK_STRETCH_EN
         w_stretch_nxt   = 1'b0;
      end else if (r_stretch) begin
         if (tx_valid) begin
            w_shift_nxt   = data_tx[6:0];
            w_sda_oe_nxt  = ~data_tx[7];
            w_state_nxt   = S_READ;
            w_bitcnt_nxt  = '0;
            w_stretch_nxt = 1'b0;
         end
`endif
      end else begin
         case (r_state)
            S_ADDR: begin
               if (w_scl_rise) begin
                  w_shift_nxt  = {r_shift[5:0], w_sda_f};
                  w_bitcnt_nxt = r_bitcnt + 4'd1;
                  if (r_bitcnt == 4'd7) begin
                     w_bitcnt_nxt = '0;
                     w_phase_nxt  = 1'b0;
                     // General call (0x00) never matches, even if ADDRESS were 0.
                     if (r_shift == ADDRESS && ADDRESS != 7'h00) begin
                        w_mode_nxt  = w_sda_f;
                        w_state_nxt = S_ADDR_ACK;
                     end else begin
                        w_state_nxt = S_WAIT_STOP;
                     end
                  end
               end
            end
            S_ADDR_ACK: begin
               if (w_scl_fall) begin
                  if (!r_phase) begin
                     w_sda_oe_nxt    = 1'b1;
                     w_addressed_nxt = 1'b1;
                     w_phase_nxt     = 1'b1;
                  end else begin
                     w_phase_nxt  = 1'b0;
                     w_bitcnt_nxt = '0;
                     if (r_mode) begin
                        w_load = 1'b1;
                     end else begin
                        w_sda_oe_nxt = 1'b0;
                        w_state_nxt  = S_WRITE;
                     end
                  end
               end else if (w_scl_rise && r_phase && r_mode) begin
                  w_tx_req_nxt = 1'b1;
               end
            end
            S_WRITE: begin
               if (w_scl_rise) begin
                  w_shift_nxt  = {r_shift[5:0], w_sda_f};
                  w_bitcnt_nxt = r_bitcnt + 4'd1;
                  if (r_bitcnt == 4'd7) begin
                     w_data_rx_nxt  = {r_shift, w_sda_f};
                     w_rx_valid_nxt = 1'b1;
                     w_ack_en_nxt   = rx_ack;
                     w_bitcnt_nxt   = '0;
                     w_phase_nxt    = 1'b0;
                     w_state_nxt    = S_WRITE_ACK;
                  end
               end
            end
            S_WRITE_ACK: begin
               if (w_scl_fall) begin
                  if (!r_phase) begin
                     w_sda_oe_nxt = r_ack_en;
                     w_phase_nxt  = 1'b1;
                  end else begin
                     w_sda_oe_nxt = 1'b0;
                     w_phase_nxt  = 1'b0;
                     w_state_nxt  = S_WRITE;
                  end
               end
            end
            S_READ: begin
               // Bit 7 went out at load; falls 1..7 present bits 6..0, fall 8 ends the byte.
               if (w_scl_rise) begin
                  w_bitcnt_nxt = r_bitcnt + 4'd1;
               end else if (w_scl_fall) begin
                  if (r_bitcnt == 4'd8) begin
                     w_sda_oe_nxt = 1'b0;
                     w_phase_nxt  = 1'b0;
                     w_state_nxt  = S_READ_ACK;
                  end else begin
                     w_shift_nxt  = {r_shift[5:0], 1'b0};
                     w_sda_oe_nxt = ~r_shift[6];
                  end
               end
            end
            S_READ_ACK: begin
               if (w_scl_rise) begin
                  if (!w_sda_f) begin
                     w_tx_req_nxt = 1'b1;
                     w_phase_nxt  = 1'b1;
                  end else begin
                     w_nack_nxt  = 1'b1;
                     w_state_nxt = S_WAIT_STOP;
                  end
               end else if (w_scl_fall && r_phase) begin
                  w_phase_nxt  = 1'b0;
                  w_bitcnt_nxt = '0;
                  w_load       = 1'b1;
               end
            end
            default: ;
         endcase
      end
      if (w_load) begin
`ifdef I2C_TARGET_CLOCK_STRETCH_EN
         w_sda_oe_nxt  = 1'b0;
         w_stretch_nxt = 1'b1;
`else
         w_shift_nxt  = data_tx[6:0];
         w_sda_oe_nxt = ~data_tx[7];
         w_state_nxt  = S_READ;
         w_bitcnt_nxt = '0;
`endif
      end
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_bitcnt    <= '0;
         r_shift     <= '0;
         r_phase     <= 1'b0;
         r_sda_oe    <= 1'b0;
         r_addressed <= 1'b0;
         r_busy      <= 1'b0;
         r_mode      <= 1'b0;
         r_nack      <= 1'b0;
         r_data_rx   <= '0;
         r_rx_valid  <= 1'b0;
         r_tx_req    <= 1'b0;
         r_ack_en    <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_bitcnt    <= w_bitcnt_nxt;
         r_shift     <= w_shift_nxt;
         r_phase     <= w_phase_nxt;
         r_sda_oe    <= w_sda_oe_nxt;
         r_addressed <= w_addressed_nxt;
         r_busy      <= w_busy_nxt;
         r_mode      <= w_mode_nxt;
         r_nack      <= w_nack_nxt;
         r_data_rx   <= w_data_rx_nxt;
         r_rx_valid  <= w_rx_valid_nxt;
         r_tx_req    <= w_tx_req_nxt;
         r_ack_en    <= w_ack_en_nxt;
      end
   end

`ifdef I2C_TARGET_CLOCK_STRETCH_EN
   // r_stretch_d keeps SCL low one cycle past the load so bit 7 settles on SDA first.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         r_stretch   <= 1'b0;
         r_stretch_d <= 1'b0;
      end else begin
         r_stretch   <= w_stretch_nxt;
         r_stretch_d <= r_stretch;
      end
   end
   assign scl = (r_stretch | r_stretch_d) ? 1'b0 : 1'bz;
`else
   logic w_unused_tx_valid;
   assign w_unused_tx_valid = tx_valid;
   assign scl = 1'bz;
`endif

   assign sda         = r_sda_oe ? 1'b0 : 1'bz;
   assign busy        = r_busy;
   assign addressed   = r_addressed;
   assign mode        = r_mode;
   assign data_rx     = r_data_rx;
   assign rx_valid    = r_rx_valid;
   assign tx_request  = r_tx_req;
   assign nack        = r_nack;
   assign o_dbg_state = r_state;

endmodule

// File: doc/i2c_target.md
Name: i2c_target

Overview:
- 7-bit-address I2C target (slave) core, the bus counterpart of i2c_core (the controller).
- Oversamples SCL/SDA on clk_in and detects START, repeated START and STOP.
- Matches its address, then ACKs and delivers write bytes to the user, or shifts out user-supplied read bytes.
- Sits beside i2c_core in the library; used for on-chip peripherals and as a loopback target for controller benches.

Parameters:
- ADDRESS, 7'h50, 7-bit target address compared against the first byte after START.
- FILTER_DEPTH, 3, number of consecutive equal synchronised samples required before an SCL/SDA level change is accepted. Range 1-15.

Ports:
- clk_in  input  1  system clock; must be ≥ 20× SCL rate.
- rst_n  input  1  asynchronous active-low reset.
- scl  inout  1  open-drain; released ('z') except when stretching.
- sda  inout  1  open-drain; driven only to 0, otherwise 'z'.
- rx_ack  input  1  1 = ACK received write bytes, 0 = NACK; sampled when the 8th bit is captured.
- data_tx  input  8  byte to send on a read.
- tx_valid  input  1  data_tx valid; used only with the stretch feature.
- busy  output  1  high from START until STOP.
- addressed  output  1  high from address ACK until next START/STOP.
- mode  output  1  R/W bit of the current transaction (1 = controller reads).
- data_rx  output  8  last received write byte.
- rx_valid  output  1  one-cycle strobe when data_rx updates.
- tx_request  output  1  one-cycle strobe asking for the next data_tx.
- nack  output  1  controller NACKed the last read byte; held until next START.

Behaviour:
- Reset: all outputs 0, scl/sda released, state IDLE, shift register 0x00.
- Input path: 2-FF synchroniser, then FILTER_DEPTH glitch filter, giving filtered scl_f/sda_f. Rise/fall flags last one clk_in cycle. Total latency from pin to flag is 2+FILTER_DEPTH cycles.
- START: sda_f falls while scl_f is high. Valid in any state, including mid-byte (repeated START). Sets busy=1 and clears addressed and nack, then goes to ADDR with bit count 0.
- STOP: sda_f rises while scl_f is high. Valid in any state. Goes to IDLE, busy=0, addressed=0, all drives released.
- If START and STOP occur in the same cycle (impossible on a legal bus), STOP wins.
- Bits are sampled on scl_f rising edges. SDA changes only on scl_f falling edges.
- States:
  - IDLE: drives released; waits for START.
  - ADDR: shifts 8 bits MSB-first. On the 8th rise: if bits[7:1]==ADDRESS, latch mode=bit0 and go to ADDR_ACK; otherwise go to WAIT_STOP.
  - ADDR_ACK: drive sda=0 from the next scl fall through the following fall. addressed=1 from the first fall.
    - mode=1: tx_request pulses on the ACK-bit rise; data_tx is loaded into the shifter at the ACK-ending fall; next state READ.
    - mode=0: next state WRITE.
  - WRITE: shift 8 bits. On the 8th rise: data_rx=shifter, rx_valid=1 for one cycle, latch rx_ack; then WRITE_ACK.
  - WRITE_ACK: drive sda=0 for one bit if the latched rx_ack=1, else release; back to WRITE. A NACKed byte is still presented on data_rx.
  - READ: drive sda=0 for each 0 bit, release for each 1 bit, changing on falls. After the 8th bit's fall, release SDA and go to READ_ACK.
  - READ_ACK: sample SDA on the rise.
    - Low (ACK): tx_request pulse; data_tx loaded at the next fall; back to READ.
    - High (NACK): nack=1, go to WAIT_STOP.
  - WAIT_STOP: drives released; ignores bits until START/STOP.
- General call (address 0x00) is not supported and is treated as a mismatch.
- An asynchronous reset mid-transfer releases SDA immediately and returns to IDLE. The next transfer is recognised only at a fresh START.

Optional Feature:
- Macro: I2C_TARGET_CLOCK_STRETCH_EN.
- Enabled: at the falling edge where data_tx would be loaded, hold scl low (drive 0) until tx_valid=1.
  - Load data_tx on the tx_valid cycle.
  - Present bit 7 on SDA, then release SCL one cycle later.
  - tx_valid outside a request window is ignored.
- Disabled: tx_valid is unused, scl is never driven (constant 'z'), and data_tx is sampled blindly at the fall. The user must supply data within half an SCL period after tx_request.

Test Plan:
1. START, 0xA0 (addr 0x50 write), ACK from target, byte 0x3C, rx_ack=1, STOP → target ACKs both bytes; data_rx=0x3C; one rx_valid pulse; busy falls after STOP.
2. START, 0xA2 (addr 0x51), 0xFF → SDA never driven low; addressed=0; rx_valid never pulses.
3. START, 0xA1, data_tx=0xB4; controller ACKs, then data_tx=0x5A, controller NACKs; STOP → bus carries 0xB4 then 0x5A; two tx_request pulses; nack=1 after the second byte.
4. Write 0xA0 + 0x11, then repeated START + 0xA1 with no STOP between → mode changes 0→1; busy stays 1; read byte equals data_tx.
5. Write byte 0x77 with rx_ack=0 → 9th-bit SDA is high; data_rx=0x77; rx_valid still pulses.
6. With stretch enabled, read with tx_valid delayed 500 cycles → SCL held low ~500 cycles; byte transmitted intact. Also: assert rst_n=0 mid-byte → SDA released within 1 cycle and state is IDLE.
